// File: rtl/vc_pkg.sv
// vc_pkg: victim-cache constants, controller state encoding and tag/way helpers
package vc_pkg;
  localparam int S_OFFSET = 5;
  localparam int S_LINE = 256;
  localparam int TAG_WIDTH = 32 - S_OFFSET;
  localparam int SIZE_OF_VC = 8;
  localparam int WAY_BITS = $clog2(SIZE_OF_VC);
  typedef enum logic [2:0] {IDLE, LOOKUP, HIT, WB, INSERT, FETCH, RESP} vc_state_e;
  function automatic logic [TAG_WIDTH-1:0] get_tag(input logic [31:0] addr);
    return addr[31:S_OFFSET];
  endfunction
  function automatic logic [WAY_BITS-1:0] lowest_one(input logic [SIZE_OF_VC-1:0] v);
    lowest_one = '0;
    for (int i = SIZE_OF_VC - 1; i >= 0; i--) if (v[i]) lowest_one = WAY_BITS'(i);
  endfunction
endpackage

// File: rtl/vc_plru.sv
// vc_plru: 7-bit tree PLRU (clk, rst, touch_en, touch_way in; victim_way out)
module vc_plru
  import vc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                touch_en,
  input  logic [WAY_BITS-1:0] touch_way,
  output logic [WAY_BITS-1:0] victim_way
);
  logic [SIZE_OF_VC-2:0] tree_q, tree_d;
  logic [2:0] t1, t2, v1, v2;
  assign t1 = 3'd1 + {2'b0, touch_way[2]};
  assign t2 = 3'd3 + {1'b0, touch_way[2:1]};
  assign v1 = 3'd1 + {2'b0, tree_q[0]};
  assign v2 = 3'd3 + {1'b0, tree_q[0], tree_q[v1]};
  assign victim_way = {tree_q[0], tree_q[v1], tree_q[v2]};
  always_ff @(posedge clk) tree_q <= rst ? '0 : tree_d;
  always_comb begin
    tree_d = tree_q;
    if (touch_en) begin
      tree_d[0] = ~touch_way[2];
      tree_d[t1] = ~touch_way[1];
      tree_d[t2] = ~touch_way[0];
    end
  end
endmodule

// File: rtl/vc_control.sv
// vc_control: victim-cache controller (L1 miss request/response, victim-store strobes, pmem read/write)
module vc_control
  import vc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  l1_req,
  input  logic [31:0]           l1_addr,
  input  logic                  l1_evict_valid,
  input  logic                  l1_evict_dirty,
  input  logic [31:0]           l1_evict_addr,
  input  logic [S_LINE-1:0]     l1_evict_data,
  output logic                  vc_l1_resp,
  output logic                  vc_l1_hit,
  output logic [S_LINE-1:0]     vc_l1_rdata256,
  output logic                  vc_tag_cmp,
  output logic [TAG_WIDTH-1:0]  vc_tag_store_datain,
  output logic [SIZE_OF_VC-1:0] vc_tag_store_ld_mask,
  input  logic [SIZE_OF_VC-1:0] vc_tag_hit_vec,
  output logic [WAY_BITS-1:0]   vc_way_sel,
  input  logic [TAG_WIDTH-1:0]  vc_tag_rdata,
  input  logic [S_LINE-1:0]     vc_vcmem_rdata256,
  output logic [S_LINE-1:0]     vc_datastore_datain,
  output logic [SIZE_OF_VC-1:0] vc_datastore_ld_mask,
  output logic [SIZE_OF_VC-1:0] vc_valid_ld,
  output logic [SIZE_OF_VC-1:0] vc_dirty_ld,
  output logic                  vc_valid_datain,
  output logic                  vc_dirty_datain,
  input  logic [SIZE_OF_VC-1:0] vc_valid_dataout,
  input  logic [SIZE_OF_VC-1:0] vc_dirty_dataout,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [31:0]           pmem_address,
  output logic [S_LINE-1:0]     pmem_wdata256,
  input  logic                  pmem_resp,
  input  logic [S_LINE-1:0]     pmem_rdata256
);
  vc_state_e state_q, state_d;
  logic [TAG_WIDTH-1:0] miss_tag_q, miss_tag_d, ev_tag_q, ev_tag_d;
  logic ev_valid_q, ev_valid_d, ev_dirty_q, ev_dirty_d, hit_q, hit_d;
  logic [S_LINE-1:0] ev_data_q, ev_data_d, rdata_q, rdata_d;
  logic [WAY_BITS-1:0] way_q, way_d, plru_victim, victim;
  logic [SIZE_OF_VC-1:0] way_oh;
  logic touch_en;
  logic unused_ok;
  assign unused_ok = ^{l1_addr[S_OFFSET-1:0], l1_evict_addr[S_OFFSET-1:0]};
  assign way_oh = SIZE_OF_VC'(1) << way_q;
  assign victim = |(~vc_valid_dataout) ? lowest_one(~vc_valid_dataout) : plru_victim;
  assign vc_tag_store_datain = state_q == LOOKUP ? miss_tag_q : ev_tag_q;
  assign vc_datastore_datain = ev_data_q;
  assign pmem_wdata256 = vc_vcmem_rdata256;
  assign vc_l1_rdata256 = rdata_q;
  assign vc_l1_hit = hit_q;
  vc_plru u_plru (
    .clk        (clk),
    .rst        (rst),
    .touch_en   (touch_en),
    .touch_way  (way_q),
    .victim_way (plru_victim)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      miss_tag_q <= '0;
      ev_tag_q   <= '0;
      ev_valid_q <= 1'b0;
      ev_dirty_q <= 1'b0;
      ev_data_q  <= '0;
      way_q      <= '0;
      rdata_q    <= '0;
      hit_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      miss_tag_q <= miss_tag_d;
      ev_tag_q   <= ev_tag_d;
      ev_valid_q <= ev_valid_d;
      ev_dirty_q <= ev_dirty_d;
      ev_data_q  <= ev_data_d;
      way_q      <= way_d;
      rdata_q    <= rdata_d;
      hit_q      <= hit_d;
    end
  end
  always_comb begin
    state_d = state_q;
    miss_tag_d = miss_tag_q;
    ev_tag_d = ev_tag_q;
    ev_valid_d = ev_valid_q;
    ev_dirty_d = ev_dirty_q;
    ev_data_d = ev_data_q;
    way_d = way_q;
    rdata_d = rdata_q;
    hit_d = hit_q;
    vc_l1_resp = 1'b0;
    vc_tag_cmp = 1'b0;
    vc_tag_store_ld_mask = '0;
    vc_datastore_ld_mask = '0;
    vc_valid_ld = '0;
    vc_dirty_ld = '0;
    vc_valid_datain = 1'b0;
    vc_dirty_datain = 1'b0;
    vc_way_sel = '0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_address = '0;
    touch_en = 1'b0;
    case (state_q)
      IDLE: if (l1_req) begin
        miss_tag_d = get_tag(l1_addr);
        ev_tag_d = get_tag(l1_evict_addr);
        ev_valid_d = l1_evict_valid;
        ev_dirty_d = l1_evict_dirty;
        ev_data_d = l1_evict_data;
        state_d = LOOKUP;
      end
      LOOKUP: begin
        vc_tag_cmp = 1'b1;
        way_d = |vc_tag_hit_vec ? lowest_one(vc_tag_hit_vec) : victim;
        state_d = |vc_tag_hit_vec ? HIT :
                  !ev_valid_q ? FETCH :
                  (vc_valid_dataout[victim] && vc_dirty_dataout[victim]) ? WB : INSERT;
      end
      HIT: begin
        // a hit without an evicted line hands the line to L1, so the way is freed
        vc_way_sel = way_q;
        rdata_d = vc_vcmem_rdata256;
        hit_d = 1'b1;
        touch_en = 1'b1;
        vc_valid_ld = way_oh;
        vc_valid_datain = ev_valid_q;
        vc_tag_store_ld_mask = ev_valid_q ? way_oh : '0;
        vc_datastore_ld_mask = ev_valid_q ? way_oh : '0;
        vc_dirty_ld = ev_valid_q ? way_oh : '0;
        vc_dirty_datain = ev_dirty_q;
        state_d = RESP;
      end
      WB: begin
        vc_way_sel = way_q;
        pmem_write = 1'b1;
        pmem_address = {vc_tag_rdata, {S_OFFSET{1'b0}}};
        state_d = pmem_resp ? INSERT : WB;
      end
      INSERT: begin
        vc_tag_store_ld_mask = way_oh;
        vc_datastore_ld_mask = way_oh;
        vc_valid_ld = way_oh;
        vc_dirty_ld = way_oh;
        vc_valid_datain = 1'b1;
        vc_dirty_datain = ev_dirty_q;
        touch_en = 1'b1;
        state_d = FETCH;
      end
      FETCH: begin
        pmem_read = 1'b1;
        pmem_address = {miss_tag_q, {S_OFFSET{1'b0}}};
        if (pmem_resp) begin
          rdata_d = pmem_rdata256;
          hit_d = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        vc_l1_resp = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_vc_control.sv
// tb_vc_control: directed vector table plus randomized transactions against a behavioural victim-cache model
module tb_vc_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic l1_req = 1'b0;
  logic [31:0] l1_addr = '0;
  logic l1_evict_valid = 1'b0;
  logic l1_evict_dirty = 1'b0;
  logic [31:0] l1_evict_addr = '0;
  logic [255:0] l1_evict_data = '0;
  logic vc_l1_resp, vc_l1_hit, vc_tag_cmp;
  logic [255:0] vc_l1_rdata256, vc_vcmem_rdata256, vc_datastore_datain, pmem_wdata256, pmem_rdata256;
  logic [26:0] vc_tag_store_datain, vc_tag_rdata;
  logic [7:0] vc_tag_store_ld_mask, vc_tag_hit_vec, vc_datastore_ld_mask, vc_valid_ld, vc_dirty_ld;
  logic [7:0] vc_valid_dataout, vc_dirty_dataout;
  logic [2:0] vc_way_sel;
  logic vc_valid_datain, vc_dirty_datain, pmem_read, pmem_write;
  logic [31:0] pmem_address;
  logic pmem_resp = 1'b0;

  vc_control dut (
    .clk(clk), .rst(rst), .l1_req(l1_req), .l1_addr(l1_addr),
    .l1_evict_valid(l1_evict_valid), .l1_evict_dirty(l1_evict_dirty),
    .l1_evict_addr(l1_evict_addr), .l1_evict_data(l1_evict_data),
    .vc_l1_resp(vc_l1_resp), .vc_l1_hit(vc_l1_hit), .vc_l1_rdata256(vc_l1_rdata256),
    .vc_tag_cmp(vc_tag_cmp), .vc_tag_store_datain(vc_tag_store_datain),
    .vc_tag_store_ld_mask(vc_tag_store_ld_mask), .vc_tag_hit_vec(vc_tag_hit_vec),
    .vc_way_sel(vc_way_sel), .vc_tag_rdata(vc_tag_rdata), .vc_vcmem_rdata256(vc_vcmem_rdata256),
    .vc_datastore_datain(vc_datastore_datain), .vc_datastore_ld_mask(vc_datastore_ld_mask),
    .vc_valid_ld(vc_valid_ld), .vc_dirty_ld(vc_dirty_ld),
    .vc_valid_datain(vc_valid_datain), .vc_dirty_datain(vc_dirty_datain),
    .vc_valid_dataout(vc_valid_dataout), .vc_dirty_dataout(vc_dirty_dataout),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata256(pmem_wdata256), .pmem_resp(pmem_resp), .pmem_rdata256(pmem_rdata256)
  );

  function automatic logic [255:0] pm_line(input logic [26:0] t);
    return {8{32'hC0DE0000 ^ {5'b0, t}}} ^ {t, 229'h0};
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  logic [26:0] st_tag [8];
  logic [255:0] st_data [8];
  logic [7:0] st_valid = '0;
  logic [7:0] st_dirty = '0;
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (vc_tag_store_ld_mask[i]) st_tag[i] <= vc_tag_store_datain;
      if (vc_datastore_ld_mask[i]) st_data[i] <= vc_datastore_datain;
      if (vc_dirty_ld[i]) st_dirty[i] <= vc_dirty_datain;
      if (rst) st_valid[i] <= 1'b0;
      else if (vc_valid_ld[i]) st_valid[i] <= vc_valid_datain;
    end
  end
  always_comb for (int i = 0; i < 8; i++) vc_tag_hit_vec[i] = st_valid[i] && st_tag[i] == vc_tag_store_datain;
  assign vc_valid_dataout = st_valid;
  assign vc_dirty_dataout = st_dirty;
  assign vc_tag_rdata = st_tag[vc_way_sel];
  assign vc_vcmem_rdata256 = st_data[vc_way_sel];
  assign pmem_rdata256 = pm_line(pmem_address[31:5]);

  int checks = 0;
  int fails = 0;
  task automatic chk(input string n, input logic [255:0] g, input logic [255:0] e);
    checks++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s got %h want %h", n, g, e);
    end
  endtask
  task automatic chki(input string n, input int g, input int e);
    checks++;
    if (g != e) begin
      fails++;
      $display("FAIL %s got %0d want %0d", n, g, e);
    end
  endtask

  logic [26:0] rm_tag [8];
  logic [255:0] rm_data [8];
  bit rm_valid [8];
  bit rm_dirty [8];
  bit pl [7];
  function automatic int pl_victim();
    int n = 0, w = 0;
    for (int l = 0; l < 3; l++) begin
      w = 2 * w + int'(pl[n]);
      n = 2 * n + 1 + int'(pl[n]);
    end
    return w;
  endfunction
  task automatic pl_touch(input int w);
    int n = 0, b;
    for (int l = 0; l < 3; l++) begin
      b = (w >> (2 - l)) & 1;
      pl[n] = (b == 0);
      n = 2 * n + 1 + b;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    l1_req = 1'b0;
    pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) rm_valid[i] = 0;
    for (int i = 0; i < 7; i++) pl[i] = 0;
  endtask

  logic got_hit;
  logic [255:0] got_rdata, wr_data;
  logic [31:0] rd_addr, wr_addr;
  logic [7:0] ld_mask;
  int rd_cnt, wr_cnt, resp_cyc, ld_cyc, wr_cyc;

  task automatic run_txn(input logic [31:0] a, input logic ev, input logic evd, input logic [31:0] ea, input logic [255:0] ed);
    logic [26:0] mt;
    logic hit;
    logic [255:0] e_rdata, e_wr_data;
    logic [31:0] e_wr_addr;
    int w, e_rd, e_wr, lat, cyc;
    logic done;
    mt = a[31:5];
    hit = 1'b0;
    w = 0;
    e_rd = 0;
    e_wr = 0;
    e_wr_addr = '0;
    e_wr_data = '0;
    for (int i = 7; i >= 0; i--) if (rm_valid[i] && rm_tag[i] == mt) begin hit = 1'b1; w = i; end
    if (hit) begin
      e_rdata = rm_data[w];
      if (ev) begin
        rm_tag[w] = ea[31:5]; rm_data[w] = ed; rm_valid[w] = 1; rm_dirty[w] = evd;
      end else rm_valid[w] = 0;
      pl_touch(w);
    end else begin
      w = -1;
      for (int i = 7; i >= 0; i--) if (!rm_valid[i]) w = i;
      if (w < 0) w = pl_victim();
      if (ev) begin
        if (rm_valid[w] && rm_dirty[w]) begin
          e_wr = 1; e_wr_addr = {rm_tag[w], 5'b0}; e_wr_data = rm_data[w];
        end
        rm_tag[w] = ea[31:5]; rm_data[w] = ed; rm_valid[w] = 1; rm_dirty[w] = evd;
        pl_touch(w);
      end
      e_rd = 1;
      e_rdata = pm_line(mt);
    end
    l1_req = 1'b1; l1_addr = a; l1_evict_valid = ev; l1_evict_dirty = evd; l1_evict_addr = ea; l1_evict_data = ed;
    rd_cnt = 0; wr_cnt = 0; ld_cyc = -1; wr_cyc = -1; ld_mask = '0; done = 1'b0; cyc = 0;
    got_hit = 1'b0; got_rdata = '0; resp_cyc = 0;
    lat = $urandom_range(0, 3);
    while (!done && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      chki("strobe_onehot", int'($onehot0(vc_tag_store_ld_mask) && $onehot0(vc_datastore_ld_mask) &&
           $onehot0(vc_valid_ld) && $onehot0(vc_dirty_ld)), 1);
      if (vc_tag_store_ld_mask != 0 && ld_cyc < 0) begin ld_cyc = cyc; ld_mask = vc_tag_store_ld_mask; end
      if (vc_l1_resp) begin
        done = 1'b1; got_hit = vc_l1_hit; got_rdata = vc_l1_rdata256; resp_cyc = cyc; l1_req = 1'b0;
      end
      if (pmem_resp) pmem_resp = 1'b0;
      else if (pmem_read || pmem_write) begin
        if (lat == 0) begin
          pmem_resp = 1'b1;
          lat = $urandom_range(0, 3);
          if (pmem_write) begin wr_cnt++; wr_addr = pmem_address; wr_data = pmem_wdata256; wr_cyc = cyc; end
          else begin rd_cnt++; rd_addr = pmem_address; end
        end else lat--;
      end else if ($urandom_range(0, 7) == 0) pmem_resp = 1'b1;
    end
    pmem_resp = 1'b0;
    l1_req = 1'b0;
    chki("resp_seen", int'(done), 1);
    if (done) begin
      @(posedge clk);
      @(negedge clk);
      chki("resp_one_cycle", int'(vc_l1_resp), 0);
      chk("rdata_held", vc_l1_rdata256, got_rdata);
    end
    chki("hit", int'(got_hit), int'(hit));
    chk("rdata", got_rdata, e_rdata);
    chki("rd_cnt", rd_cnt, e_rd);
    chki("wr_cnt", wr_cnt, e_wr);
    if (e_rd != 0) chk("rd_addr", 256'(rd_addr), 256'({mt, 5'b0}));
    if (e_wr != 0) begin
      chk("wr_addr", 256'(wr_addr), 256'(e_wr_addr));
      chk("wr_data", wr_data, e_wr_data);
    end
    if (hit) chki("hit_latency", resp_cyc, 3);
    chki("tag_ld_way", int'(ld_mask), ev ? (1 << w) : 0);
    for (int i = 0; i < 8; i++) begin
      chki("st_valid", int'(st_valid[i]), int'(rm_valid[i]));
      if (rm_valid[i]) begin
        chk("st_tag", 256'(st_tag[i]), 256'(rm_tag[i]));
        chk("st_data", st_data[i], rm_data[i]);
        chki("st_dirty", int'(st_dirty[i]), int'(rm_dirty[i]));
      end
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic        ev;
    logic        evd;
    logic [31:0] ea;
    logic        hit;
    int          rd;
    logic [31:0] rda;
  } vec_t;
  vec_t tbl [7];

  initial begin
    tbl[0] = '{32'h0000_1040, 1'b1, 1'b0, 32'h0000_2000, 1'b0, 1, 32'h0000_1040};
    tbl[1] = '{32'h0000_2000, 1'b1, 1'b1, 32'h0000_3000, 1'b1, 0, 32'h0};
    tbl[2] = '{32'h0000_3000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 0, 32'h0};
    tbl[3] = '{32'h0000_3000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1, 32'h0000_3000};
    tbl[4] = '{32'h0000_1047, 1'b1, 1'b1, 32'h0000_5000, 1'b0, 1, 32'h0000_1040};
    tbl[5] = '{32'h0000_6000, 1'b1, 1'b0, 32'h0000_7000, 1'b0, 1, 32'h0000_6000};
    tbl[6] = '{32'h0000_5000, 1'b1, 1'b0, 32'h0000_8000, 1'b1, 0, 32'h0};
    for (int i = 0; i < 8; i++) begin rm_valid[i] = 0; rm_dirty[i] = 0; end
    for (int i = 0; i < 7; i++) pl[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chki("rst_state", int'(dut.state_q), int'(vc_pkg::IDLE));
    chki("rst_ctrl", int'({vc_l1_resp, vc_l1_hit, vc_tag_cmp, pmem_read, pmem_write, vc_way_sel}), 0);
    chki("rst_strobes", int'({vc_tag_store_ld_mask, vc_datastore_ld_mask, vc_valid_ld, vc_dirty_ld}), 0);
    chk("rst_rdata", vc_l1_rdata256, '0);
    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i].a, tbl[i].ev, tbl[i].evd, tbl[i].ea, rand_line());
      chki("vec_hit", int'(got_hit), int'(tbl[i].hit));
      chki("vec_rd", rd_cnt, tbl[i].rd);
      chki("vec_wr", wr_cnt, 0);
      if (tbl[i].rd != 0) chk("vec_rda", 256'(rd_addr), 256'(tbl[i].rda));
      if (i == 0) chki("way0_install", int'({st_valid[0], st_dirty[0], st_tag[0]}), int'({2'b10, 27'h100}));
      if (i == 1) chki("way0_swap", int'({st_valid[0], st_dirty[0], st_tag[0]}), int'({2'b11, 27'h180}));
      if (i == 2) chki("hit_clears_valid", int'(st_valid[0]), 0);
    end
    do_reset();
    for (int i = 0; i < 8; i++) run_txn({27'h800 + 27'(i), 5'b0}, 1'b1, 1'b1, {27'h400 + 27'(i), 5'b0}, rand_line());
    for (int i = 6; i >= 0; i--) run_txn({27'h400 + 27'(i), 5'b0}, 1'b1, 1'b1, {27'h500 + 27'(i), 5'b0}, rand_line());
    run_txn({27'h900, 5'b0}, 1'b1, 1'b0, {27'h600, 5'b0}, rand_line());
    chki("victim_wb_cnt", wr_cnt, 1);
    chk("victim_wb_addr", 256'(wr_addr), 256'({27'h407, 5'b0}));
    chki("victim_way7", int'(ld_mask), 8'h80);
    chki("insert_after_wb", ld_cyc, wr_cyc + 1);
    do_reset();
    begin
      int n;
      n = 0;
      l1_req = 1'b1; l1_addr = 32'h0000_A000; l1_evict_valid = 1'b0;
      while (!pmem_read && n < 20) begin @(posedge clk); n++; @(negedge clk); end
      l1_req = 1'b0;
      chki("fetch_reached", int'(pmem_read), 1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chki("rst_drops_read", int'(pmem_read), 0);
      chki("rst_fetch_state", int'(dut.state_q), int'(vc_pkg::IDLE));
      rst = 1'b0;
      for (int i = 0; i < 8; i++) rm_valid[i] = 0;
      for (int i = 0; i < 7; i++) pl[i] = 0;
    end
    run_txn(32'h0000_A000, 1'b1, 1'b1, 32'h0000_B000, rand_line());
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a, ea;
      a = {27'h40 + 27'($urandom_range(0, 11)), 5'($urandom)};
      ea = {27'h40 + 27'($urandom_range(0, 11)), 5'($urandom)};
      run_txn(a, 1'($urandom_range(0, 3) != 0), 1'($urandom), ea, rand_line());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/vc_control.md
# vc_control

Victim-cache controller: the control stage directly upstream of the victim-cache `stores` block. It accepts L1 miss requests and looks up the miss line in the fully associative 8-entry victim cache. On a hit it swaps the resident line with L1's evicted line. On a miss it writes back a dirty VC victim, installs L1's evicted line and fetches the miss line from physical memory. It drives every tag/data/meta strobe of the stores and owns a tree-PLRU for replacement.

## Interface
- `s_offset`, 5, byte-offset bits per line
- `s_line`, 256, line width in bits
- `tag_width`, 27, `32 - s_offset` (fully associative)
- `size_of_vc`, 8, entries
- `way_bits`, 3, `$clog2(size_of_vc)`

Ports (one clock, `clk`; reset `rst` is synchronous and active-high):
- `clk` in 1: clock
- `rst` in 1: synchronous active-high reset
- `l1_req` in 1: L1 miss request, held until `vc_l1_resp`
- `l1_addr` in 32: miss address
- `l1_evict_valid` in 1: L1 supplies an evicted line
- `l1_evict_dirty` in 1: evicted line dirty
- `l1_evict_addr` in 32: evicted line address
- `l1_evict_data` in `s_line`: evicted line
- `vc_l1_resp` out 1: one-cycle completion pulse
- `vc_l1_hit` out 1: valid with resp; 1 = served from VC
- `vc_l1_rdata256` out `s_line`: miss line, valid with resp, held until next resp
- `vc_tag_cmp` out 1: compare strobe
- `vc_tag_store_datain` out `tag_width`: compare/write tag
- `vc_tag_store_ld_mask` out `size_of_vc`: one-hot tag write
- `vc_tag_hit_vec` in `size_of_vc`: combinational match vector (valid-qualified)
- `vc_way_sel` out `way_bits`: read way for data and tag mux
- `vc_tag_rdata` in `tag_width`: tag of `vc_way_sel`
- `vc_vcmem_rdata256` in `s_line`: line of `vc_way_sel`
- `vc_datastore_datain` out `s_line`; `vc_datastore_ld_mask` out `size_of_vc`
- `vc_valid_ld`, `vc_dirty_ld` out `size_of_vc`: one-hot meta writes
- `vc_valid_datain`, `vc_dirty_datain` out 1
- `vc_valid_dataout`, `vc_dirty_dataout` in `size_of_vc`
- `pmem_read`, `pmem_write` out 1: held until `pmem_resp`
- `pmem_address` out 32: line aligned (low `s_offset` bits zero)
- `pmem_wdata256` out `s_line`
- `pmem_resp` in 1; `pmem_rdata256` in `s_line`

## Operation
- Request capture: IDLE latches `l1_addr` and all evict fields when `l1_req` = 1. It then moves to LOOKUP.
- LOOKUP: drive `vc_tag_cmp` = 1 with the miss tag `addr[31:5]`.
  - Any hit bit set: go to HIT; the hit way is the lowest set bit.
  - No hit: select the victim way. The victim is the lowest invalid way; if all ways are valid, it is the PLRU victim.
  - Miss, victim valid and dirty, and `l1_evict_valid`: go to WB.
  - Miss, `l1_evict_valid` set, no dirty victim: go to INSERT.
  - Miss, no evicted line: go to FETCH.
- HIT: drive `vc_way_sel` = hit way and capture `vc_vcmem_rdata256` into the response register.
  - If `l1_evict_valid`: in the same cycle, write evict tag, data, valid = 1 and dirty = `l1_evict_dirty` into the hit way.
  - Otherwise: clear valid on the hit way.
  - Touch PLRU with the hit way. Go to RESP with hit = 1.
- WB: drive `pmem_write` with address {`vc_tag_rdata`, 5'b0} and data = the victim line. On `pmem_resp`, go to INSERT.
- INSERT: write the evicted line into the victim way, setting valid = 1 and dirty = `l1_evict_dirty`. Touch PLRU with the victim way. Go to FETCH.
- FETCH: drive `pmem_read` with address {miss tag, 5'b0}. On `pmem_resp`, capture `pmem_rdata256` and go to RESP with hit = 0.
- RESP: `vc_l1_resp` = 1 for one cycle, then go to IDLE.
- PLRU: 7-bit tree.
  - Touch sets each node on the path to point away from the touched way.
  - Victim follows the node pointers.
- Write strobes are one-hot and asserted for exactly one cycle per write.

## Timing
- Hit latency: 3 cycles from the accept edge to the `vc_l1_resp` cycle (IDLE → LOOKUP → HIT → RESP).
- Clean miss: LOOKUP → INSERT → FETCH (N wait cycles) → RESP.
- L1 must deassert `l1_req` in the cycle after `vc_l1_resp`; if it stays high, that cycle is a new request.
- Reset values:
  - All strobes, `vc_l1_resp`, `pmem_read` and `pmem_write` are 0.
  - `vc_l1_rdata256` = 0, `vc_l1_hit` = 0, `vc_way_sel` = 0.
  - PLRU bits = 0 and state = IDLE.
- Reset mid-transaction aborts: any pmem request drops the next cycle and no partial store write issues. The stores reset their own valid bits.
- `pmem_resp` is ignored outside WB and FETCH.

## Structure
- `vc_pkg` holds:
  - the state enum (IDLE, LOOKUP, HIT, WB, INSERT, FETCH, RESP);
  - the `s_offset`, `tag_width`, `size_of_vc` and `way_bits` constants;
  - a tag-extract function.
- Sub-module `vc_plru`: inputs `touch_en` and `touch_way`; output `victim_way`; holds the 7-bit tree state and has a synchronous reset.

## Test plan
- Reset, then read outputs → all outputs 0, state IDLE.
- Empty VC; request `l1_addr` = 0x0000_1040 with evict 0x0000_2000 clean → `pmem_read` at 0x0000_1040. Way 0 gets valid = 1, dirty = 0, tag 0x100. On `pmem_resp`, `vc_l1_resp` = 1 with hit = 0.
- Way 0 holds tag 0x100; request 0x0000_2000 with evict 0x0000_3000 dirty → resp in cycle 3 with hit = 1 and the stored line. Way 0 becomes tag 0x180 with dirty = 1. No pmem activity.
- Fill all 8 ways, all dirty; touch ways 0–6 → the next miss victimises way 7. `pmem_write` targets way 7's address; INSERT follows the resp of that write.
- Hit with `l1_evict_valid` = 0 → the hit way's valid clears.
- Assert `rst` while in FETCH with `pmem_read` high → `pmem_read` drops the next cycle and state = IDLE.
